// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ready handshake, fetch/decode buffer, branch redirect.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of truncating them.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH, DRAIN, FAULT} state_t;
`else
  typedef enum logic [0:0] {FETCH, DRAIN} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] target;
  logic [31:0] load_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign target = branch_base + branch_offset;
`else
  // Without the trap, the low two bits are simply dropped.
  assign target = (branch_base + branch_offset) & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    load_pc      = pending_pc_q;
    imem_req     = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d      = fault_q;
`endif
    case (state_q)
      FETCH: begin
        imem_req = !(valid_q && stall);
        if (branch_taken) begin
          valid_d = 1'b0;
          instr_d = NOP_WORD;
          if (imem_req && !imem_ready) begin
            // Keep the wrong-path address on the bus until memory answers.
            pending_pc_d = target;
            state_d      = DRAIN;
          end
`ifdef FETCH_MISALIGN_TRAP_EN
          else if (target[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
`endif
          else begin
            pc_d = target;
          end
        end else if (imem_req && imem_ready) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'd4;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_WORD;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pending_pc_d = target;
        end
        if (imem_ready) begin
          load_pc = branch_taken ? target : pending_pc_q;
          state_d = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (load_pc[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = load_pc;
          end
`else
          pc_d = load_pc;
`endif
        end
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pending_pc_q <= 32'd0;
      instr_q      <= NOP_WORD;
      pc_out_q     <= 32'd0;
      valid_q      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q      <= fault_d;
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then random traffic against a reference model.
// Honours FETCH_MISALIGN_TRAP_EN when the design is built with it.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ready, stall, branch_taken;
  logic        instr_valid, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, branch_base, branch_offset, instruction, pc_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_base(branch_base), .branch_offset(branch_offset),
    .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5677;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of PC, buffer and redirect bookkeeping.
  logic [31:0] m_pc, m_target_wait, m_instr, m_pcout;
  bit          m_waiting, m_dead, m_valid;

  function automatic bit m_req(input bit st);
    if (m_dead) return 1'b0;
    if (m_waiting) return 1'b1;
    return !(m_valid && st);
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_target_wait = 32'h0; m_instr = NOP; m_pcout = 32'h0;
    m_waiting = 0; m_dead = 0; m_valid = 0;
  endtask

  task automatic m_redirect_to(input logic [31:0] t);
    if (TRAP && t[1:0] != 2'b00) m_dead = 1;
    else m_pc = t;
  endtask

  task automatic m_step(input bit st, input bit rdy, input bit br,
                        input logic [31:0] base, input logic [31:0] off);
    logic [31:0] t;
    bit req;
    req = m_req(st);
    t = base + off;
    if (!TRAP) t[1:0] = 2'b00;
    if (m_dead) return;
    if (m_waiting) begin
      if (br) m_target_wait = t;
      if (rdy) begin
        m_waiting = 0;
        m_redirect_to(m_target_wait);
      end
    end else if (br) begin
      m_valid = 0; m_instr = NOP;
      if (req && !rdy) begin
        m_waiting = 1; m_target_wait = t;
      end else begin
        m_redirect_to(t);
      end
    end else if (req && rdy) begin
      m_instr = mem_word(m_pc); m_pcout = m_pc; m_valid = 1; m_pc = m_pc + 4;
    end else if (!st) begin
      m_valid = 0; m_instr = NOP;
    end
  endtask

  // Asserts reset asynchronously mid-cycle, checks, releases at a falling edge.
  task automatic do_reset();
    reset = 1'b1; stall = 0; imem_ready = 1; branch_taken = 0;
    branch_base = 0; branch_offset = 0;
    #1;
    m_reset();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, NOP);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          st, rdy, br;
    logic [31:0] base, off;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pcout;
    bit          e_fault;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit rdy, input bit br,
                              input logic [31:0] base, input logic [31:0] off,
                              input bit e_req, input logic [31:0] e_addr,
                              input bit e_valid, input logic [31:0] e_pcout, input bit e_fault);
    vec_t v;
    v.st = st; v.rdy = rdy; v.br = br; v.base = base; v.off = off;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pcout = e_pcout;
    v.e_fault = e_fault;
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    // Stream, 3-cycle stall at pc 8, same-cycle redirect, drain with wait states,
    // double redirect in drain, then a misaligned target.
    tbl[0]  = mk(0,1,0, 0,0,                     1, 32'h00, 1, 32'h00, 0);
    tbl[1]  = mk(0,1,0, 0,0,                     1, 32'h04, 1, 32'h04, 0);
    tbl[2]  = mk(0,1,0, 0,0,                     1, 32'h08, 1, 32'h08, 0);
    tbl[3]  = mk(1,1,0, 0,0,                     0, 32'h0C, 1, 32'h08, 0);
    tbl[4]  = mk(1,1,0, 0,0,                     0, 32'h0C, 1, 32'h08, 0);
    tbl[5]  = mk(1,1,0, 0,0,                     0, 32'h0C, 1, 32'h08, 0);
    tbl[6]  = mk(0,1,0, 0,0,                     1, 32'h0C, 1, 32'h0C, 0);
    tbl[7]  = mk(0,1,0, 0,0,                     1, 32'h10, 1, 32'h10, 0);
    tbl[8]  = mk(0,1,1, 32'h10,32'hFFFF_FFF8,    1, 32'h14, 0, 32'h10, 0);
    tbl[9]  = mk(0,1,0, 0,0,                     1, 32'h08, 1, 32'h08, 0);
    tbl[10] = mk(0,1,0, 0,0,                     1, 32'h0C, 1, 32'h0C, 0);
    tbl[11] = mk(0,1,0, 0,0,                     1, 32'h10, 1, 32'h10, 0);
    tbl[12] = mk(0,0,1, 32'h30,32'h10,           1, 32'h14, 0, 32'h10, 0);
    tbl[13] = mk(0,0,0, 0,0,                     1, 32'h14, 0, 32'h10, 0);
    tbl[14] = mk(0,1,0, 0,0,                     1, 32'h14, 0, 32'h10, 0);
    tbl[15] = mk(0,1,0, 0,0,                     1, 32'h40, 1, 32'h40, 0);
    tbl[16] = mk(0,0,1, 32'h40,32'h0,            1, 32'h44, 0, 32'h40, 0);
    tbl[17] = mk(0,0,1, 32'h80,32'h0,            1, 32'h44, 0, 32'h40, 0);
    tbl[18] = mk(0,1,0, 0,0,                     1, 32'h44, 0, 32'h40, 0);
    tbl[19] = mk(0,1,0, 0,0,                     1, 32'h80, 1, 32'h80, 0);
    tbl[20] = mk(0,1,1, 32'h20,32'h2,            1, 32'h84, 0, 32'h80, TRAP);
    if (TRAP) tbl[21] = mk(0,1,0, 0,0,           0, 32'h0,  0, 32'h80, 1);
    else      tbl[21] = mk(0,1,0, 0,0,           1, 32'h20, 1, 32'h20, 0);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      stall = tbl[i].st; imem_ready = tbl[i].rdy; branch_taken = tbl[i].br;
      branch_base = tbl[i].base; branch_offset = tbl[i].off;
      #1;
      chk($sformatf("t%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
      @(posedge clk); #1;
      chk($sformatf("t%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("t%0d_pc_out", i), pc_out, tbl[i].e_pcout);
      chk($sformatf("t%0d_instr", i), instruction,
          tbl[i].e_valid ? mem_word(tbl[i].e_pcout) : NOP);
      chk($sformatf("t%0d_fault", i), {31'd0, fetch_fault}, {31'd0, tbl[i].e_fault});
      @(negedge clk);
    end

    // With the trap, the fault persists with no request until reset.
    if (TRAP) begin
      repeat (3) @(negedge clk);
      #1;
      chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
      chk("fault_no_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
    end

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit st, rdy, br;
      logic [31:0] base, off;
      if ($urandom_range(0, 99) == 0 || (m_dead && $urandom_range(0, 9) == 0)) begin
        do_reset();
        continue;
      end
      st   = ($urandom_range(0, 3) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      br   = ($urandom_range(0, 7) == 0);
      base = $urandom & 32'hFFFF_FFFC;
      off  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFE)
                                          : (32'($urandom_range(0, 64)) << 1);
      stall = st; imem_ready = rdy; branch_taken = br;
      branch_base = base; branch_offset = off;
      #1;
      chk("r_req", {31'd0, imem_req}, {31'd0, m_req(st)});
      if (m_req(st)) chk("r_addr", imem_addr, m_pc);
      m_step(st, rdy, br, base, off);
      @(posedge clk); #1;
      chk("r_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("r_pc_out", pc_out, m_pcout);
      chk("r_instr", instruction, m_instr);
      chk("r_fault", {31'd0, fetch_fault}, {31'd0, m_dead});
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
